// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: plays an 8-entry table of {last, pattern, ms} steps
// in order, looping until stopped. A prescaler turns CLK into 1 ms ticks,
// and a per-step tick counter times each step.
module led_pattern_sched #(
    parameter int TICK_DIV = 50_000,
    parameter int N_STEP   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Cfg_Wr,
    input  logic [2:0]  Cfg_Addr,
    input  logic [20:0] Cfg_Data,
    input  logic        Start,
    input  logic        Stop,
    output logic [3:0]  LED_Out,
    output logic        Busy,
    output logic [2:0]  Step_Idx,
    output logic        Cycle_Done
);

    localparam int             PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [2:0]     LAST_IDX = 3'(N_STEP - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [20:0]       r_table [N_STEP];

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [15:0]       r_ms_cnt;
    logic [2:0]        r_step;
    logic [3:0]        r_pat;
    logic              r_last;
    logic [15:0]       r_dur_m1;
    logic              r_cycle_done;

    logic              w_tick;
    logic              w_step_end;
    logic              w_wrap;
    logic              w_entry;
    logic [2:0]        w_step_next;
    logic [2:0]        w_sel_idx;
    logic [20:0]       w_sel_entry;
    logic [15:0]       w_sel_dur_m1;

    // Step sequencing helpers. The next entry is read from the table before
    // any same-edge write lands, so a write is seen one edge later.
    assign w_tick       = (r_pre_cnt == PRE_LAST);
    assign w_step_end   = w_tick && (r_ms_cnt == r_dur_m1);
    assign w_wrap       = r_last || (r_step == LAST_IDX);
    assign w_step_next  = w_wrap ? 3'd0 : r_step + 3'd1;
    assign w_entry      = (r_state == S_IDLE) && Start && !Stop;
    assign w_sel_idx    = w_entry ? 3'd0 : w_step_next;
    assign w_sel_entry  = r_table[w_sel_idx];
    // A zero duration plays as 1 ms, so the compare value is clamped at 0.
    assign w_sel_dur_m1 = (w_sel_entry[15:0] == 16'd0) ? 16'd0
                                                       : w_sel_entry[15:0] - 16'd1;

    // Step table: cleared on reset, writable in any state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_STEP; i++) begin
                r_table[i] <= '0;
            end
        end else if (Cfg_Wr) begin
            r_table[Cfg_Addr] <= Cfg_Data;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: Stop always wins; Start is ignored while running.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start && !Stop) w_state_next = S_RUN;
            S_RUN:   if (Stop)           w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Prescaler, per-step ms counter, and latched step contents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pre_cnt    <= '0;
            r_ms_cnt     <= '0;
            r_step       <= '0;
            r_pat        <= '0;
            r_last       <= 1'b0;
            r_dur_m1     <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_pre_cnt <= '0;
                r_ms_cnt  <= '0;
                r_step    <= '0;
                if (w_entry) begin
                    r_pat    <= w_sel_entry[19:16];
                    r_last   <= w_sel_entry[20];
                    r_dur_m1 <= w_sel_dur_m1;
                end
            end else if (Stop) begin
                r_pre_cnt <= '0;
                r_ms_cnt  <= '0;
                r_step    <= '0;
                r_pat     <= '0;
            end else begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
                if (w_step_end) begin
                    r_ms_cnt     <= '0;
                    r_step       <= w_step_next;
                    r_pat        <= w_sel_entry[19:16];
                    r_last       <= w_sel_entry[20];
                    r_dur_m1     <= w_sel_dur_m1;
                    r_cycle_done <= w_wrap;
                end else if (w_tick) begin
                    r_ms_cnt <= r_ms_cnt + 16'd1;
                end
            end
        end
    end

    // Outputs are forced dark/idle outside RUN so reset and Stop act at once.
    always_comb begin
        LED_Out    = 4'd0;
        Busy       = 1'b0;
        Step_Idx   = 3'd0;
        Cycle_Done = 1'b0;
        if (r_state == S_RUN) begin
            LED_Out    = r_pat;
            Busy       = 1'b1;
            Step_Idx   = r_step;
            Cycle_Done = r_cycle_done;
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched with TICK_DIV=4: a directed vector table,
// hand-written multi-cycle sequences, and random traffic against a
// cycles-remaining reference model.
module tb_led_pattern_sched;

    localparam int TD = 4;

    logic        CLK;
    logic        RST;
    logic        Cfg_Wr;
    logic [2:0]  Cfg_Addr;
    logic [20:0] Cfg_Data;
    logic        Start;
    logic        Stop;
    logic [3:0]  LED_Out;
    logic        Busy;
    logic [2:0]  Step_Idx;
    logic        Cycle_Done;

    int checks = 0;
    int errors = 0;

    led_pattern_sched #(.TICK_DIV(TD), .N_STEP(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Cfg_Wr     (Cfg_Wr),
        .Cfg_Addr   (Cfg_Addr),
        .Cfg_Data   (Cfg_Data),
        .Start      (Start),
        .Stop       (Stop),
        .LED_Out    (LED_Out),
        .Busy       (Busy),
        .Step_Idx   (Step_Idx),
        .Cycle_Done (Cycle_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: table copy, running flag, and cycles left in the step.
    logic [20:0] m_tbl [8];
    bit          m_run;
    int          m_step;
    logic [3:0]  m_pat;
    bit          m_last;
    int          m_rem;
    bit          m_cd;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        m_run = 0; m_step = 0; m_pat = '0; m_last = 0; m_rem = 0; m_cd = 0;
    endtask

    task automatic model_load(input int idx);
        int d;
        m_pat  = m_tbl[idx][19:16];
        m_last = m_tbl[idx][20];
        d      = int'(m_tbl[idx][15:0]);
        m_rem  = ((d == 0) ? 1 : d) * TD;
    endtask

    // Advance the model by one clock edge using the inputs driven before it.
    task automatic model_edge();
        if (RST) begin
            model_reset();
            return;
        end
        m_cd = 0;
        if (!m_run) begin
            if (Start && !Stop) begin
                m_run  = 1;
                m_step = 0;
                model_load(0);
            end
        end else if (Stop) begin
            m_run  = 0;
            m_step = 0;
            m_pat  = '0;
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_last || m_step == 7) begin
                    m_step = 0;
                    m_cd   = 1;
                end else begin
                    m_step++;
                end
                model_load(m_step);
            end
        end
        if (Cfg_Wr) m_tbl[Cfg_Addr] = Cfg_Data;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One clock: edge, model update, sample 1 ns later, release strobes.
    task automatic tick(input bit use_model);
        int exp_v;
        int act_v;
        @(posedge CLK);
        model_edge();
        #1;
        if (use_model) begin
            exp_v = {(m_run ? m_pat : 4'd0), m_run, (m_run ? 3'(m_step) : 3'd0), m_cd};
            act_v = {LED_Out, Busy, Step_Idx, Cycle_Done};
            chk("model{led,busy,idx,cd}", act_v, exp_v);
        end
        Cfg_Wr = 1'b0;
        Start  = 1'b0;
        Stop   = 1'b0;
    endtask

    task automatic wait_cd(input int exp_n, input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (Cycle_Done) begin
                n = i;
                break;
            end
        end
        chk(name, n, exp_n);
        $display("cycle_done %s after %0d cycles (want %0d)", name, n, exp_n);
    endtask

    task automatic cfg(input logic [2:0] a, input logic [20:0] d);
        Cfg_Wr = 1'b1; Cfg_Addr = a; Cfg_Data = d;
        tick(1);
        $display("write entry%0d = %06h", a, d);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [20:0] data;
        logic        start;
        logic        stop;
        logic [3:0]  led;
        logic        busy;
        logic [2:0]  idx;
        logic        cd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Zero-duration single step, Stop/Start interplay.
        vecs[0]  = '{1'b1, 3'd0, 21'h1F0000, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 21'h000000, 1'b1, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b1};
        vecs[6]  = '{1'b0, 3'd0, 21'h000000, 1'b1, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 21'h000000, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 21'h000000, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 21'h000000, 1'b1, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 21'h000000, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 1'b0};

        RST = 1'b1; Cfg_Wr = 1'b0; Cfg_Addr = '0; Cfg_Data = '0;
        Start = 1'b0; Stop = 1'b0;
        model_reset();

        // Reset values.
        tick(1);
        tick(1);
        chk("reset led", LED_Out, 0);
        chk("reset busy", Busy, 0);
        chk("reset idx", Step_Idx, 0);
        chk("reset cd", Cycle_Done, 0);
        RST = 1'b0;
        tick(1);

        // Unconfigured table: 8 dark 4-cycle steps, wrap after 32.
        Start = 1'b1;
        tick(1);
        wait_cd(32, "default wrap");
        chk("default led", LED_Out, 0);
        Stop = 1'b1;
        tick(1);

        // Directed vector table.
        for (int v = 0; v < 14; v++) begin
            Cfg_Wr = vecs[v].wr; Cfg_Addr = vecs[v].addr; Cfg_Data = vecs[v].data;
            Start  = vecs[v].start; Stop = vecs[v].stop;
            tick(0);
            chk($sformatf("vec%0d led", v), LED_Out, vecs[v].led);
            chk($sformatf("vec%0d busy", v), Busy, vecs[v].busy);
            chk($sformatf("vec%0d idx", v), Step_Idx, vecs[v].idx);
            chk($sformatf("vec%0d cd", v), Cycle_Done, vecs[v].cd);
            $display("vec%0d led=%b busy=%b idx=%0d cd=%b", v, LED_Out, Busy, Step_Idx, Cycle_Done);
        end

        // Basic three-step loop, 24-cycle period.
        cfg(3'd0, 21'h010002);
        cfg(3'd1, 21'h020001);
        cfg(3'd2, 21'h1C0003);
        Start = 1'b1;
        tick(1);
        chk("basic first led", LED_Out, 4'b0001);
        wait_cd(24, "basic first wrap");
        wait_cd(24, "basic period");

        // Stop mid step 1, then restart from step 0.
        for (int i = 0; i < 9; i++) tick(1);
        chk("pre-stop idx", Step_Idx, 1);
        Stop = 1'b1;
        tick(1);
        chk("stop led", LED_Out, 0);
        chk("stop busy", Busy, 0);
        Start = 1'b1;
        tick(1);
        chk("restart idx", Step_Idx, 0);
        chk("restart led", LED_Out, 4'b0001);
        chk("restart busy", Busy, 1);

        // Live rewrite of the playing step, with a Start pulse during RUN.
        for (int i = 0; i < 8; i++) tick(1);
        chk("rewrite pre idx", Step_Idx, 1);
        Cfg_Wr = 1'b1; Cfg_Addr = 3'd1; Cfg_Data = 21'h0A0001; Start = 1'b1;
        tick(1);
        chk("rewrite cur led", LED_Out, 4'b0010);
        chk("rewrite cur idx", Step_Idx, 1);
        wait_cd(15, "rewrite wrap");
        for (int i = 0; i < 8; i++) tick(1);
        chk("rewrite next led", LED_Out, 4'b1010);

        // Asynchronous reset during step 2.
        wait_cd(16, "pre-reset wrap");
        for (int i = 0; i < 14; i++) tick(1);
        chk("pre-reset idx", Step_Idx, 2);
        #2 RST = 1'b1;
        #1;
        chk("async led", LED_Out, 0);
        chk("async busy", Busy, 0);
        chk("async idx", Step_Idx, 0);
        model_reset();
        tick(1);
        RST = 1'b0;
        Start = 1'b1;
        tick(1);
        wait_cd(32, "post-reset wrap");
        Stop = 1'b1;
        tick(1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            RST      = ($urandom % 400) == 0;
            Cfg_Wr   = ($urandom % 6) == 0;
            Cfg_Addr = 3'($urandom % 8);
            Cfg_Data = {1'(($urandom % 4) == 0), 4'($urandom), 16'($urandom % 3)};
            Start    = ($urandom % 20) == 0;
            Stop     = ($urandom % 50) == 0;
            tick(1);
        end
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
